// File: rtl/mpu_load_store_unit.sv
// mpu_load_store_unit: responder for MPU matrix load/store streams between memory and the matrix register file.
// Define MPU_LSU_TRANSPOSE_EN to stream stores column-major and report the swapped dimensions.
module mpu_load_store_unit #(
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_BITS = 3,
    parameter int FW              = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_req,
    input  logic                     store_req,
    input  logic [FW-1:0]            mem_load_element,
    input  logic [MBITS:0]           mem_m_load_size,
    input  logic [NBITS:0]           mem_n_load_size,
    input  logic [MATRIX_REG_BITS:0] mem_load_addr,
    input  logic [MATRIX_REG_BITS:0] mem_store_addr,
    output logic                     mem_load_ack,
    output logic                     mem_load_error,
    output logic                     mem_store_en,
    output logic [FW-1:0]            mem_store_element,
    output logic [MBITS:0]           mem_m_store_size,
    output logic [NBITS:0]           mem_n_store_size,
    output logic                     load_ready,
    output logic                     store_ready,
    output logic                     reg_load_en,
    output logic [MATRIX_REG_BITS:0] reg_load_addr,
    output logic [FW-1:0]            reg_load_element,
    output logic [MBITS:0]           reg_m_load_size,
    output logic [NBITS:0]           reg_n_load_size,
    output logic [MBITS:0]           reg_i_load_loc,
    output logic [NBITS:0]           reg_j_load_loc,
    output logic                     reg_store_en,
    output logic [MATRIX_REG_BITS:0] reg_store_addr,
    output logic [MBITS:0]           reg_i_store_loc,
    output logic [NBITS:0]           reg_j_store_loc,
    input  logic [FW-1:0]            reg_store_element,
    input  logic [MBITS:0]           reg_m_store_size,
    input  logic [NBITS:0]           reg_n_store_size
);
    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);
    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_WAIT, LOAD_ERR, STORE_SIZE, STORE_READ, STORE_DRAIN, STORE_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [MBITS:0]           i_q, i_d, load_m_q, load_m_d, store_m_q, store_m_d;
    logic [NBITS:0]           j_q, j_d, load_n_q, load_n_d, store_n_q, store_n_d;
    logic [MATRIX_REG_BITS:0] load_addr_q, load_addr_d, store_addr_q, store_addr_d;
    logic                     reg_load_en_q, reg_load_en_d;
    logic [FW-1:0]            reg_load_element_q, reg_load_element_d;
    logic [MBITS:0]           reg_i_load_loc_q, reg_i_load_loc_d;
    logic [NBITS:0]           reg_j_load_loc_q, reg_j_load_loc_d;
    logic                     rd_vld_q, rd_vld_d;

    logic [MBITS:0] lim_m, ld_i, st_i;
    logic [NBITS:0] lim_n, ld_j, st_j;
    logic           i_last, j_last, last, load_bad;

    // Counters are shared: limits come from whichever transfer is active.
    assign lim_m  = (state_q == STORE_READ) ? store_m_q : load_m_q;
    assign lim_n  = (state_q == STORE_READ) ? store_n_q : load_n_q;
    assign i_last = i_q == lim_m - M_ONE;
    assign j_last = j_q == lim_n - N_ONE;
    assign last   = i_last && j_last;
    assign ld_i   = j_last ? i_q + M_ONE : i_q;
    assign ld_j   = j_last ? '0 : j_q + N_ONE;
`ifdef MPU_LSU_TRANSPOSE_EN
    assign st_i             = i_last ? '0 : i_q + M_ONE;
    assign st_j             = i_last ? j_q + N_ONE : j_q;
    assign mem_m_store_size = store_n_q;
    assign mem_n_store_size = store_m_q;
`else
    assign st_i             = ld_i;
    assign st_j             = ld_j;
    assign mem_m_store_size = store_m_q;
    assign mem_n_store_size = store_n_q;
`endif

    assign load_bad = mem_m_load_size == '0 || mem_n_load_size == '0 ||
                      mem_m_load_size > M_MAX || mem_n_load_size > N_MAX;

    assign load_ready        = state_q == IDLE;
    assign store_ready       = state_q == IDLE;
    assign mem_load_ack      = (state_q == LOAD) && load_req;
    assign mem_load_error    = state_q == LOAD_ERR;
    assign reg_store_en      = state_q == STORE_READ;
    assign reg_i_store_loc   = reg_store_en ? i_q : '0;
    assign reg_j_store_loc   = reg_store_en ? j_q : '0;
    assign reg_store_addr    = store_addr_q;
    assign mem_store_en      = rd_vld_q;
    assign mem_store_element = rd_vld_q ? reg_store_element : '0;
    assign reg_load_en       = reg_load_en_q;
    assign reg_load_addr     = load_addr_q;
    assign reg_load_element  = reg_load_element_q;
    assign reg_m_load_size   = load_m_q;
    assign reg_n_load_size   = load_n_q;
    assign reg_i_load_loc    = reg_i_load_loc_q;
    assign reg_j_load_loc    = reg_j_load_loc_q;

    always_comb begin
        state_d            = state_q;
        i_d                = i_q;
        j_d                = j_q;
        load_m_d           = load_m_q;
        load_n_d           = load_n_q;
        load_addr_d        = load_addr_q;
        store_m_d          = store_m_q;
        store_n_d          = store_n_q;
        store_addr_d       = store_addr_q;
        reg_load_en_d      = mem_load_ack;
        reg_load_element_d = mem_load_ack ? mem_load_element : '0;
        reg_i_load_loc_d   = mem_load_ack ? i_q : '0;
        reg_j_load_loc_d   = mem_load_ack ? j_q : '0;
        rd_vld_d           = reg_store_en;
        case (state_q)
            IDLE: begin
                i_d = '0;
                j_d = '0;
                if (load_req) begin
                    load_m_d    = mem_m_load_size;
                    load_n_d    = mem_n_load_size;
                    load_addr_d = mem_load_addr;
                    state_d     = load_bad ? LOAD_ERR : LOAD;
                end else if (store_req) begin
                    store_addr_d = mem_store_addr;
                    state_d      = STORE_SIZE;
                end
            end
            LOAD: begin
                if (!load_req) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = LOAD_WAIT;
                end else begin
                    i_d = ld_i;
                    j_d = ld_j;
                end
            end
            STORE_SIZE: begin
                store_m_d = reg_m_store_size;
                store_n_d = reg_n_store_size;
                state_d   = (reg_m_store_size == '0 || reg_n_store_size == '0) ? STORE_WAIT : STORE_READ;
            end
            STORE_READ: begin
                if (last) begin
                    state_d = STORE_DRAIN;
                end else begin
                    i_d = st_i;
                    j_d = st_j;
                end
            end
            STORE_DRAIN: state_d = STORE_WAIT;
            LOAD_WAIT, LOAD_ERR: state_d = load_req ? state_q : IDLE;
            STORE_WAIT: state_d = store_req ? state_q : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= IDLE;
            i_q                <= '0;
            j_q                <= '0;
            load_m_q           <= '0;
            load_n_q           <= '0;
            load_addr_q        <= '0;
            store_m_q          <= '0;
            store_n_q          <= '0;
            store_addr_q       <= '0;
            reg_load_en_q      <= 1'b0;
            reg_load_element_q <= '0;
            reg_i_load_loc_q   <= '0;
            reg_j_load_loc_q   <= '0;
            rd_vld_q           <= 1'b0;
        end else begin
            state_q            <= state_d;
            i_q                <= i_d;
            j_q                <= j_d;
            load_m_q           <= load_m_d;
            load_n_q           <= load_n_d;
            load_addr_q        <= load_addr_d;
            store_m_q          <= store_m_d;
            store_n_q          <= store_n_d;
            store_addr_q       <= store_addr_d;
            reg_load_en_q      <= reg_load_en_d;
            reg_load_element_q <= reg_load_element_d;
            reg_i_load_loc_q   <= reg_i_load_loc_d;
            reg_j_load_loc_q   <= reg_j_load_loc_d;
            rd_vld_q           <= rd_vld_d;
        end
    end
endmodule

// File: tb/tb_mpu_load_store_unit.sv
// tb_mpu_load_store_unit: directed self-checking bench for mpu_load_store_unit with a behavioural register file.
module tb_mpu_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req, store_req;
    logic [31:0] mem_load_element;
    logic [2:0]  mem_m_load_size, mem_n_load_size;
    logic [3:0]  mem_load_addr, mem_store_addr;
    logic        mem_load_ack, mem_load_error, mem_store_en;
    logic [31:0] mem_store_element;
    logic [2:0]  mem_m_store_size, mem_n_store_size;
    logic        load_ready, store_ready, reg_load_en;
    logic [3:0]  reg_load_addr;
    logic [31:0] reg_load_element;
    logic [2:0]  reg_m_load_size, reg_n_load_size, reg_i_load_loc, reg_j_load_loc;
    logic        reg_store_en;
    logic [3:0]  reg_store_addr;
    logic [2:0]  reg_i_store_loc, reg_j_store_loc;
    logic [31:0] reg_store_element;
    logic [2:0]  reg_m_store_size, reg_n_store_size;

    localparam logic [31:0] FLT [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                        32'h40800000, 32'h40A00000, 32'h40C00000};
`ifdef MPU_LSU_TRANSPOSE_EN
    localparam logic [2:0] EM = 3'd3;
    localparam logic [2:0] EN = 3'd2;
    localparam int ORD [6] = '{0, 3, 1, 4, 2, 5};
`else
    localparam logic [2:0] EM = 3'd2;
    localparam logic [2:0] EN = 3'd3;
    localparam int ORD [6] = '{0, 1, 2, 3, 4, 5};
`endif

    logic [31:0] rf [16][4][4];
    logic [2:0]  rf_m [16] = '{default: 3'd0};
    logic [2:0]  rf_n [16] = '{default: 3'd0};
    logic [31:0] ld_data [16];
    logic [31:0] exp_st [16];
    logic [47:0] wr_q [$];
    logic [31:0] st_q [$];
    int          st_cyc [$];
    int          cyc = 0;
    int          ack_n = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          rk, rt;

    always #5 clk = ~clk;

    mpu_load_store_unit dut (
        .clk(clk), .rst(rst), .load_req(load_req), .store_req(store_req),
        .mem_load_element(mem_load_element), .mem_m_load_size(mem_m_load_size),
        .mem_n_load_size(mem_n_load_size), .mem_load_addr(mem_load_addr),
        .mem_store_addr(mem_store_addr), .mem_load_ack(mem_load_ack),
        .mem_load_error(mem_load_error), .mem_store_en(mem_store_en),
        .mem_store_element(mem_store_element), .mem_m_store_size(mem_m_store_size),
        .mem_n_store_size(mem_n_store_size), .load_ready(load_ready),
        .store_ready(store_ready), .reg_load_en(reg_load_en), .reg_load_addr(reg_load_addr),
        .reg_load_element(reg_load_element), .reg_m_load_size(reg_m_load_size),
        .reg_n_load_size(reg_n_load_size), .reg_i_load_loc(reg_i_load_loc),
        .reg_j_load_loc(reg_j_load_loc), .reg_store_en(reg_store_en),
        .reg_store_addr(reg_store_addr), .reg_i_store_loc(reg_i_store_loc),
        .reg_j_store_loc(reg_j_store_loc), .reg_store_element(reg_store_element),
        .reg_m_store_size(reg_m_store_size), .reg_n_store_size(reg_n_store_size)
    );

    // Register file: sizes read combinationally, element read with one cycle of latency.
    assign reg_m_store_size = rf_m[reg_store_addr];
    assign reg_n_store_size = rf_n[reg_store_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_load_en) begin
            rf[reg_load_addr][reg_i_load_loc[1:0]][reg_j_load_loc[1:0]] <= reg_load_element;
            rf_m[reg_load_addr] <= reg_m_load_size;
            rf_n[reg_load_addr] <= reg_n_load_size;
        end
        if (reg_store_en)
            reg_store_element <= rf[reg_store_addr][reg_i_store_loc[1:0]][reg_j_store_loc[1:0]];
    end

    always @(negedge clk) begin
        if (reg_load_en)
            wr_q.push_back({reg_load_addr, reg_m_load_size, reg_n_load_size,
                            reg_i_load_loc, reg_j_load_loc, reg_load_element});
        if (mem_store_en) begin
            st_q.push_back(mem_store_element);
            st_cyc.push_back(cyc);
        end
        if (mem_load_ack) ack_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic outs_busy();
        return |{mem_load_ack, mem_load_error, mem_store_en, mem_store_element, mem_m_store_size,
                 mem_n_store_size, reg_load_en, reg_load_addr, reg_load_element, reg_m_load_size,
                 reg_n_load_size, reg_i_load_loc, reg_j_load_loc, reg_store_en, reg_store_addr,
                 reg_i_store_loc, reg_j_store_loc};
    endfunction

    task automatic do_load(input logic [3:0] a, input logic [2:0] m, input logic [2:0] n, input int cnt);
        int k = 0;
        int t = 0;
        int a0 = ack_n;
        logic [2:0] ei, ej;
        wr_q.delete();
        mem_load_addr   = a;
        mem_m_load_size = m;
        mem_n_load_size = n;
        load_req        = 1'b1;
        @(negedge clk);
        while (k < cnt && t < cnt + 8) begin
            mem_load_element = ld_data[k];
            if (mem_load_ack) k++;
            t++;
            @(negedge clk);
        end
        check("ld_ack_run", t, cnt);
        @(negedge clk);
        check("ld_busy", {load_ready, store_ready}, 2'b00);
        check("ld_ack_total", ack_n - a0, cnt);
        load_req = 1'b0;
        @(negedge clk);
        check("ld_done", {load_ready, store_ready}, 2'b11);
        check("ld_wr_count", wr_q.size(), cnt);
        for (int q = 0; q < wr_q.size() && q < cnt; q++) begin
            ei = 3'(q / int'(n));
            ej = 3'(q % int'(n));
            check("ld_wr", wr_q[q], {a, m, n, ei, ej, ld_data[q]});
        end
    endtask

    task automatic load_err(input logic [2:0] m, input logic [2:0] n);
        int a0 = ack_n;
        mem_load_addr   = 4'd5;
        mem_m_load_size = m;
        mem_n_load_size = n;
        load_req        = 1'b1;
        repeat (3) @(negedge clk);
        check("err_flag", mem_load_error, 1'b1);
        check("err_noack", ack_n - a0, 0);
        check("err_busy", load_ready, 1'b0);
        load_req = 1'b0;
        @(negedge clk);
        check("err_exit", {mem_load_error, load_ready}, 2'b01);
    endtask

    task automatic collect_store(input int base, input int cnt, input logic [2:0] em, input logic [2:0] en);
        int t = 0;
        while (st_q.size() < cnt && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("st_count", st_q.size(), cnt);
        check("st_size", {mem_m_store_size, mem_n_store_size}, {em, en});
        if (st_q.size() > 0) begin
            check("st_first", st_cyc[0], base + 3);
            check("st_contig", st_cyc[st_q.size()-1] - st_cyc[0], cnt - 1);
        end
        for (int k = 0; k < st_q.size() && k < cnt; k++) check("st_data", st_q[k], exp_st[k]);
        check("st_busy", store_ready, 1'b0);
        store_req = 1'b0;
        @(negedge clk);
        check("st_exit", store_ready, 1'b1);
    endtask

    task automatic do_store(input logic [3:0] a, input int cnt, input logic [2:0] em, input logic [2:0] en);
        st_q.delete();
        st_cyc.delete();
        mem_store_addr = a;
        store_req      = 1'b1;
        collect_store(cyc, cnt, em, en);
    endtask

    initial begin
        load_req         = 1'b0;
        store_req        = 1'b0;
        mem_load_element = '0;
        mem_m_load_size  = '0;
        mem_n_load_size  = '0;
        mem_load_addr    = '0;
        mem_store_addr   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {load_ready, store_ready}, 2'b11);
        check("rst_outs", outs_busy(), 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int q = 0; q < 6; q++) ld_data[q] = FLT[q];
        do_load(4'd1, 3'd2, 3'd3, 6);

        load_err(3'd0, 3'd2);
        load_err(3'd5, 3'd1);
        load_err(3'd2, 3'd5);

        for (int q = 0; q < 6; q++) exp_st[q] = FLT[ORD[q]];
        do_store(4'd1, 6, EM, EN);

        // Load and store requested together: load must finish before the store starts.
        ld_data[0] = 32'h11111111;
        ld_data[1] = 32'h22222222;
        st_q.delete();
        st_cyc.delete();
        mem_store_addr = 4'd1;
        store_req      = 1'b1;
        do_load(4'd2, 3'd1, 3'd2, 2);
        check("both_store_after_load", st_q.size(), 0);
        collect_store(cyc, 6, EM, EN);

        do_store(4'd7, 0, 3'd0, 3'd0);

        // Reset on the third acknowledge of a 4x4 load.
        for (int q = 0; q < 16; q++) ld_data[q] = 32'h50000000 + q;
        wr_q.delete();
        mem_load_addr   = 4'd3;
        mem_m_load_size = 3'd4;
        mem_n_load_size = 3'd4;
        load_req        = 1'b1;
        rk = 0;
        rt = 0;
        @(negedge clk);
        while (rk < 2 && rt < 10) begin
            mem_load_element = ld_data[rk];
            if (mem_load_ack) rk++;
            rt++;
            @(negedge clk);
        end
        mem_load_element = ld_data[2];
        check("rst_mid_ack", mem_load_ack, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        load_req = 1'b0;
        check("rst_mid_ready", {load_ready, store_ready}, 2'b11);
        check("rst_mid_outs", outs_busy(), 1'b0);
        check("rst_mid_writes", wr_q.size(), 2);
        @(negedge clk);

        ld_data[0] = 32'h41200000;
        do_load(4'd4, 3'd1, 3'd1, 1);
        exp_st[0] = 32'h41200000;
        do_store(4'd4, 1, 3'd1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
